// File: rtl/threshold_pkg.sv
// Shared state encodings and default widths for the multi-channel threshold detector.
package threshold_pkg;

  localparam int unsigned DEF_N_CH     = 4;
  localparam int unsigned DEF_DATA_W   = 32;
  localparam int unsigned DEF_TIME_W   = 32;
  localparam int unsigned DEF_CNT_W    = 16;
  localparam int unsigned DEF_ABS_MODE = 1;

  typedef enum logic [1:0] {
    CH_IDLE = 2'd0,
    CH_WIN  = 2'd1,
    CH_DONE = 2'd2
  } ch_state_t;

  typedef enum logic [1:0] {
    F_IDLE    = 2'd0,
    F_COLLECT = 2'd1,
    F_REPORT  = 2'd2
  } frame_state_t;

endpackage

// File: rtl/threshold_channel.sv
// One microphone channel: magnitude, burst window FSM, peak magnitude and peak timestamp.
module threshold_channel
  import threshold_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned TIME_W   = DEF_TIME_W,
  parameter int unsigned CNT_W    = DEF_CNT_W,
  parameter int unsigned ABS_MODE = DEF_ABS_MODE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_data_valid,
  input  logic [DATA_W-1:0] i_high,
  input  logic [CNT_W-1:0]  i_zero_num,
  input  logic [TIME_W-1:0] i_timer,
  input  logic              i_start_en,
  input  logic              i_freeze,
  input  logic              i_release,
  output logic              o_hit,
  output logic              o_start,
  output logic              o_win,
  output logic              o_done,
  output logic [DATA_W-1:0] o_peak,
  output logic [TIME_W-1:0] o_time
);

  ch_state_t         r_state;
  logic [CNT_W-1:0]  r_zcnt;
  logic [DATA_W-1:0] r_peak;
  logic [TIME_W-1:0] r_time;
  logic [DATA_W-1:0] w_mag;
  logic              w_hit;

  // Negating the most negative value wraps to 2^(DATA_W-1), which is the exact unsigned magnitude.
  always_comb begin
    w_mag = i_data;
    if (ABS_MODE != 0 && i_data[DATA_W-1]) w_mag = '0 - i_data;
  end

  assign w_hit   = i_data_valid && (w_mag > i_high);
  assign o_start = w_hit && i_start_en && !i_freeze && (r_state == CH_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= CH_IDLE;
      r_zcnt  <= '0;
      r_peak  <= '0;
      r_time  <= '0;
    end else if (i_release) begin
      r_state <= CH_IDLE;
      r_zcnt  <= '0;
      r_peak  <= '0;
      r_time  <= '0;
    end else if (!i_freeze && i_data_valid) begin
      case (r_state)
        CH_IDLE: begin
          if (o_start) begin
            r_state <= CH_WIN;
            r_peak  <= w_mag;
            r_time  <= i_timer;
            r_zcnt  <= '0;
          end
        end
        CH_WIN: begin
          if (w_hit) begin
            r_zcnt <= '0;
            if (w_mag > r_peak) begin
              r_peak <= w_mag;
              r_time <= i_timer;
            end
          end else if (r_zcnt >= i_zero_num) begin
            r_state <= CH_DONE;
          end else if (r_zcnt != '1) begin
            r_zcnt <= r_zcnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_hit  = w_hit;
  assign o_win  = (r_state == CH_WIN);
  assign o_done = (r_state == CH_DONE);
  assign o_peak = r_peak;
  assign o_time = r_time;

endmodule

// File: rtl/multi_channel_threshold.sv
// N-channel threshold detector: groups per-channel bursts within a skew bound into one event
// and presents it to the localisation stage through a valid/ack handshake.
module multi_channel_threshold
  import threshold_pkg::*;
#(
  parameter int unsigned N_CH     = DEF_N_CH,
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned TIME_W   = DEF_TIME_W,
  parameter int unsigned CNT_W    = DEF_CNT_W,
  parameter int unsigned ABS_MODE = DEF_ABS_MODE
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_CH*DATA_W-1:0]   data,
  input  logic                     data_valid,
  input  logic [DATA_W-1:0]        high,
  input  logic [CNT_W-1:0]         zero_num,
  input  logic [TIME_W-1:0]        max_skew,
  input  logic                     ack,
  output logic                     valid,
  output logic [N_CH-1:0]          ch_mask,
  output logic [N_CH*TIME_W-1:0]   detect_time,
  output logic [N_CH*DATA_W-1:0]   peak_value,
  output logic                     overrun
);

  frame_state_t            r_fstate;
  logic [TIME_W-1:0]       r_timer;
  logic [TIME_W-1:0]       r_first;
  logic                    r_valid;
  logic [N_CH-1:0]         r_mask;
  logic [N_CH*TIME_W-1:0]  r_time;
  logic [N_CH*DATA_W-1:0]  r_peak;
  logic                    r_overrun;

  logic [N_CH-1:0]         w_hit;
  logic [N_CH-1:0]         w_start;
  logic [N_CH-1:0]         w_win;
  logic [N_CH-1:0]         w_done;
  logic [N_CH*TIME_W-1:0]  w_time;
  logic [N_CH*DATA_W-1:0]  w_peak;
  logic [TIME_W-1:0]       w_elapsed;
  logic                    w_open;
  logic                    w_start_en;
  logic                    w_freeze;
  logic                    w_release;

  // Modulo subtraction keeps the skew window correct across timer wrap.
  assign w_elapsed  = r_timer - r_first;
  assign w_open     = (w_elapsed < max_skew);
  assign w_start_en = (r_fstate == F_IDLE) || ((r_fstate == F_COLLECT) && w_open);
  assign w_freeze   = (r_fstate == F_REPORT);
  assign w_release  = (r_fstate == F_REPORT) && r_valid && ack;

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    threshold_channel #(
      .DATA_W   (DATA_W),
      .TIME_W   (TIME_W),
      .CNT_W    (CNT_W),
      .ABS_MODE (ABS_MODE)
    ) u_ch (
      .clk          (clk),
      .rst          (rst),
      .i_data       (data[k*DATA_W +: DATA_W]),
      .i_data_valid (data_valid),
      .i_high       (high),
      .i_zero_num   (zero_num),
      .i_timer      (r_timer),
      .i_start_en   (w_start_en),
      .i_freeze     (w_freeze),
      .i_release    (w_release),
      .o_hit        (w_hit[k]),
      .o_start      (w_start[k]),
      .o_win        (w_win[k]),
      .o_done       (w_done[k]),
      .o_peak       (w_peak[k*DATA_W +: DATA_W]),
      .o_time       (w_time[k*TIME_W +: TIME_W])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fstate  <= F_IDLE;
      r_timer   <= '0;
      r_first   <= '0;
      r_valid   <= 1'b0;
      r_mask    <= '0;
      r_time    <= '0;
      r_peak    <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (data_valid) r_timer <= r_timer + 1'b1;
      case (r_fstate)
        F_IDLE: begin
          if (|w_start) begin
            r_first  <= r_timer;
            r_fstate <= F_COLLECT;
          end
        end
        F_COLLECT: begin
          // Idle channels hold zeroed peak/time, so a plain copy leaves non-detecting slots at 0.
          if (!(|w_win) && ((&w_done) || !w_open)) begin
            r_fstate <= F_REPORT;
            r_valid  <= 1'b1;
            r_mask   <= w_done;
            r_peak   <= w_peak;
            r_time   <= w_time;
          end
        end
        F_REPORT: begin
          if (|w_hit) r_overrun <= 1'b1;
          if (r_valid && ack) begin
            r_valid  <= 1'b0;
            r_fstate <= F_IDLE;
          end
        end
        default: r_fstate <= F_IDLE;
      endcase
    end
  end

  assign valid       = r_valid;
  assign ch_mask     = r_mask;
  assign detect_time = r_time;
  assign peak_value  = r_peak;
  assign overrun     = r_overrun;

endmodule

// File: tb/tb_multi_channel_threshold.sv
// Self-checking bench: directed scenarios plus randomized traffic against a behavioural event model.
module tb_multi_channel_threshold;

  localparam int unsigned N_CH   = 4;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned TIME_W = 8;
  localparam int unsigned CNT_W  = 4;
  localparam longint      TMOD   = 256;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [N_CH*DATA_W-1:0]  data;
  logic                    data_valid;
  logic [DATA_W-1:0]       high;
  logic [CNT_W-1:0]        zero_num;
  logic [TIME_W-1:0]       max_skew;
  logic                    ack;
  logic                    valid;
  logic [N_CH-1:0]         ch_mask;
  logic [N_CH*TIME_W-1:0]  detect_time;
  logic [N_CH*DATA_W-1:0]  peak_value;
  logic                    overrun;

  int n_checks = 0;
  int n_errors = 0;
  bit running  = 0;

  always #5 clk = ~clk;

  multi_channel_threshold #(
    .N_CH     (N_CH),
    .DATA_W   (DATA_W),
    .TIME_W   (TIME_W),
    .CNT_W    (CNT_W),
    .ABS_MODE (1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .data        (data),
    .data_valid  (data_valid),
    .high        (high),
    .zero_num    (zero_num),
    .max_skew    (max_skew),
    .ack         (ack),
    .valid       (valid),
    .ch_mask     (ch_mask),
    .detect_time (detect_time),
    .peak_value  (peak_value),
    .overrun     (overrun)
  );

  // ---------------- behavioural model ----------------
  // Frame mode: 0 waiting, 1 collecting, 2 reporting. Channel phase: 0 idle, 1 open, 2 closed.
  int     m_mode;
  longint m_timer, m_first;
  int     m_phase [N_CH];
  longint m_peak  [N_CH];
  longint m_ptime [N_CH];
  int     m_lows  [N_CH];
  bit     m_valid, m_ovr;
  bit     m_mask  [N_CH];
  longint m_opeak [N_CH];
  longint m_otime [N_CH];

  task automatic model_reset();
    m_mode = 0; m_timer = 0; m_first = 0; m_valid = 0; m_ovr = 0;
    for (int k = 0; k < N_CH; k++) begin
      m_phase[k] = 0; m_peak[k] = 0; m_ptime[k] = 0; m_lows[k] = 0;
      m_mask[k] = 0; m_opeak[k] = 0; m_otime[k] = 0;
    end
  endtask

  task automatic model_step();
    longint mag [N_CH];
    bit     hit [N_CH];
    longint hv;
    bit any_hit, any_open, all_closed, in_time, any_start;
    hv = high;
    any_hit = 0; any_open = 0; all_closed = 1; any_start = 0;
    for (int k = 0; k < N_CH; k++) begin
      longint v;
      v = $signed(data[k*DATA_W +: DATA_W]);
      if (v < 0) v = -v;
      mag[k] = v;
      hit[k] = data_valid && (v > hv);
      any_hit |= hit[k];
      any_open |= (m_phase[k] == 1);
      all_closed &= (m_phase[k] == 2);
    end
    if (m_mode == 2) begin
      if (any_hit) m_ovr = 1;
      if (m_valid && ack) begin
        m_valid = 0;
        m_mode  = 0;
        for (int k = 0; k < N_CH; k++) begin
          m_phase[k] = 0; m_peak[k] = 0; m_ptime[k] = 0; m_lows[k] = 0;
        end
      end
    end else begin
      in_time = (m_mode == 0) || (((m_timer - m_first + TMOD) % TMOD) < longint'(max_skew));
      if (m_mode == 1 && !any_open && (all_closed || !in_time)) begin
        m_mode  = 2;
        m_valid = 1;
        for (int k = 0; k < N_CH; k++) begin
          m_mask[k]  = (m_phase[k] == 2);
          m_opeak[k] = m_mask[k] ? m_peak[k]  : 0;
          m_otime[k] = m_mask[k] ? m_ptime[k] : 0;
        end
      end else if (data_valid) begin
        for (int k = 0; k < N_CH; k++) begin
          if (m_phase[k] == 0) begin
            if (hit[k] && in_time) begin
              m_phase[k] = 1; m_peak[k] = mag[k]; m_ptime[k] = m_timer; m_lows[k] = 0;
              any_start = 1;
            end
          end else if (m_phase[k] == 1) begin
            if (hit[k]) begin
              m_lows[k] = 0;
              if (mag[k] > m_peak[k]) begin
                m_peak[k] = mag[k]; m_ptime[k] = m_timer;
              end
            end else begin
              // window closes on the (zero_num+1)th consecutive quiet sample
              m_lows[k]++;
              if (m_lows[k] > int'(zero_num)) m_phase[k] = 2;
            end
          end
        end
        if (m_mode == 0 && any_start) begin
          m_mode = 1; m_first = m_timer;
        end
      end
    end
    if (data_valid) m_timer = (m_timer + 1) % TMOD;
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) model_reset();
    else      model_step();
  end

  // ---------------- cycle compare ----------------
  always @(negedge clk) begin
    if (running) begin
      logic [N_CH-1:0]        em;
      logic [N_CH*TIME_W-1:0] et;
      logic [N_CH*DATA_W-1:0] ep;
      for (int k = 0; k < N_CH; k++) begin
        em[k] = m_mask[k];
        et[k*TIME_W +: TIME_W] = TIME_W'(m_otime[k]);
        ep[k*DATA_W +: DATA_W] = DATA_W'(m_opeak[k]);
      end
      n_checks++;
      if (valid !== m_valid || ch_mask !== em || overrun !== m_ovr ||
          detect_time !== et || peak_value !== ep) begin
        n_errors++;
        $display("FAIL cycle_compare @%0t: got valid=%b mask=%b ovr=%b time=%h peak=%h, expected valid=%b mask=%b ovr=%b time=%h peak=%h",
                 $time, valid, ch_mask, overrun, detect_time, peak_value, m_valid, em, m_ovr, et, ep);
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic expect_eq(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Inputs are set away from the edge, held through one rising edge, then the task returns 1ns later.
  task automatic tick(input logic dv_i, input logic [N_CH*DATA_W-1:0] d, input logic ack_i);
    data_valid = dv_i; data = d; ack = ack_i;
    @(posedge clk); #1;
  endtask

  function automatic logic [N_CH*DATA_W-1:0] mk(input logic [31:0] a, input logic [31:0] b,
                                                input logic [31:0] c, input logic [31:0] d);
    return {d, c, b, a};
  endfunction

  task automatic wait_valid(input string name);
    for (int i = 0; i < 200 && valid !== 1'b1; i++) tick(1, '0, 0);
    expect_eq(name, valid, 1);
  endtask

  task automatic skew_event(input string tag, input int sk, input logic [N_CH-1:0] em);
    longint t0;
    logic [N_CH*TIME_W-1:0] et;
    logic [N_CH*DATA_W-1:0] ep;
    logic [N_CH*DATA_W-1:0] d;
    high = 100; zero_num = 1; max_skew = TIME_W'(sk);
    t0 = m_timer;
    for (int i = 0; i < 8; i++) begin
      d = '0;
      for (int k = 0; k < N_CH; k++) if (i == 2*k) d[k*DATA_W +: DATA_W] = 32'(200 + k);
      tick(1, d, 0);
    end
    wait_valid({tag, "_valid"});
    et = '0; ep = '0;
    for (int k = 0; k < N_CH; k++) if (em[k]) begin
      et[k*TIME_W +: TIME_W] = TIME_W'((t0 + 2*k) % TMOD);
      ep[k*DATA_W +: DATA_W] = 32'(200 + k);
    end
    expect_eq({tag, "_mask"}, ch_mask, em);
    expect_eq({tag, "_time"}, detect_time, et);
    expect_eq({tag, "_peak"}, peak_value, ep);
    tick(1, '0, 1);
    expect_eq({tag, "_ack"}, valid, 0);
  endtask

  function automatic logic [31:0] rnd_sample();
    int r, s;
    r = $urandom_range(0, 15);
    case (r)
      0: return $urandom();
      1: return 32'd1000;
      2: return 32'hFFFF_FC18;
      3: return 32'd1001;
      4: return 32'hFFFF_FC17;
      5: return 32'h8000_0000;
      default: begin
        s = int'($urandom_range(0, 1998)) - 999;
        return 32'(s);
      end
    endcase
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    longint t1;
    rst = 1; data = '0; data_valid = 0; high = 100; zero_num = 2; max_skew = 3; ack = 0;
    #1 rst = 0;
    running = 1;
    repeat (2) @(posedge clk);
    #1;
    expect_eq("reset_valid", valid, 0);
    expect_eq("reset_mask", ch_mask, 0);
    expect_eq("reset_time", detect_time, 0);
    expect_eq("reset_peak", peak_value, 0);
    expect_eq("reset_overrun", overrun, 0);
    rst = 1;

    // Single-channel burst from a freshly reset timer.
    tick(1, mk(0, 0, 0, 0), 0);
    tick(1, mk(150, 0, 0, 0), 0);
    tick(1, mk(300, 0, 0, 0), 0);
    tick(1, mk(200, 0, 0, 0), 0);
    tick(1, mk(50, 0, 0, 0), 0);
    tick(1, mk(50, 0, 0, 0), 0);
    tick(1, mk(50, 0, 0, 0), 0);
    expect_eq("s1_not_yet_valid", valid, 0);
    tick(1, '0, 0);
    expect_eq("s1_valid_latency", valid, 1);
    expect_eq("s1_mask", ch_mask, 4'b0001);
    expect_eq("s1_peak", peak_value, mk(300, 0, 0, 0));
    expect_eq("s1_time", detect_time, 32'h0000_0002);
    tick(1, '0, 1);
    expect_eq("s1_ack", valid, 0);

    skew_event("skew5", 5, 4'b0111);
    skew_event("skew7", 7, 4'b1111);

    for (int i = 0; i < 600 && m_timer != 252; i++) tick(1, '0, 0);
    skew_event("wrap5", 5, 4'b0111);

    // Most-negative sample and an equal repeat peak.
    high = 32'h7FFF_FFFF; zero_num = 0; max_skew = 0;
    t1 = m_timer;
    tick(1, mk(32'h8000_0000, 32'h8000_0001, 0, 0), 0);
    tick(1, mk(32'h8000_0000, 0, 0, 0), 0);
    tick(1, '0, 0);
    wait_valid("abs_valid");
    expect_eq("abs_mask", ch_mask, 4'b0001);
    expect_eq("abs_peak", peak_value, mk(32'h8000_0000, 0, 0, 0));
    expect_eq("abs_time", detect_time, 32'(TIME_W'(t1)));
    expect_eq("ovr_before", overrun, 0);

    for (int i = 0; i < 20; i++) tick(1, mk(32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000), 0);
    expect_eq("hold_valid", valid, 1);
    expect_eq("hold_overrun", overrun, 1);
    expect_eq("hold_peak", peak_value, mk(32'h8000_0000, 0, 0, 0));
    expect_eq("hold_mask", ch_mask, 4'b0001);
    tick(1, mk(32'h8000_0000, 0, 0, 0), 1);
    expect_eq("ack_valid_low", valid, 0);
    high = 100;
    t1 = m_timer;
    tick(1, mk(500, 0, 0, 0), 0);
    tick(1, '0, 0);
    wait_valid("renew_valid");
    expect_eq("renew_time", detect_time, 32'(TIME_W'(t1)));
    expect_eq("renew_peak", peak_value, mk(500, 0, 0, 0));
    tick(1, '0, 1);

    // Reset in the middle of an open window.
    zero_num = 3; max_skew = 0;
    tick(1, mk(0, 400, 0, 0), 0);
    data = '0; data_valid = 0;
    #1 rst = 0;
    #1;
    expect_eq("midrst_valid", valid, 0);
    expect_eq("midrst_mask", ch_mask, 0);
    expect_eq("midrst_overrun", overrun, 0);
    expect_eq("midrst_peak", peak_value, 0);
    rst = 1;
    tick(1, mk(0, 0, 300, 0), 0);
    wait_valid("postrst_valid");
    expect_eq("postrst_mask", ch_mask, 4'b0100);
    expect_eq("postrst_time", detect_time, 0);
    tick(1, '0, 1);

    // Randomized traffic.
    high = 1000;
    for (int c = 0; c < 4000; c++) begin
      logic [N_CH*DATA_W-1:0] d;
      if (c % 150 == 0) begin
        case ($urandom_range(0, 4))
          0: zero_num = 0;
          1: zero_num = 1;
          2: zero_num = 2;
          3: zero_num = 3;
          default: zero_num = 15;
        endcase
        max_skew = TIME_W'($urandom_range(0, 8));
      end
      if (c == 1500) begin
        rst = 0; #2; rst = 1;
      end
      for (int k = 0; k < N_CH; k++) d[k*DATA_W +: DATA_W] = rnd_sample();
      tick($urandom_range(0, 3) != 0, d, $urandom_range(0, 3) == 0);
    end

    @(negedge clk);
    running = 0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
